// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, trained from execute.
// Lookup is combinational (zero latency); training takes effect the cycle after resolve; no backpressure.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  output logic [XLEN-1:0]  f_pred_target,
  input  logic             e_valid,
  input  logic [XLEN-1:0]  e_pc,
  input  logic             e_is_branch,
  input  logic             e_is_jump,
  input  logic             e_taken,
  input  logic [XLEN-1:0]  e_target,
  input  logic             e_pred_taken,
  input  logic [XLEN-1:0]  e_pred_target,
  output logic             e_mispredict,
  output logic [XLEN-1:0]  e_redirect_pc,
  output logic [CNT_W-1:0] perf_ctrl,
  output logic [CNT_W-1:0] perf_mispredict
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_ONE << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_ONE;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic             r_jump   [ENTRIES];
  logic [CTR_W-1:0] r_ctr    [ENTRIES];
  logic [CNT_W-1:0] r_perf_ctrl;
  logic [CNT_W-1:0] r_perf_mispredict;

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic [IDX_W-1:0] w_e_idx;
  logic [TAG_W-1:0] w_e_tag;
  logic             w_e_hit;
  logic             w_act;

  assign w_f_idx = f_pc[IDX_W+1:2];
  assign w_f_tag = f_pc[XLEN-1:IDX_W+2];
  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

  assign f_pred_taken  = w_f_hit && (r_jump[w_f_idx] || r_ctr[w_f_idx][CTR_W-1]);
  assign f_pred_target = f_pred_taken ? r_target[w_f_idx] : f_pc + XLEN'(4);

  assign w_e_idx = e_pc[IDX_W+1:2];
  assign w_e_tag = e_pc[XLEN-1:IDX_W+2];
  assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);

  // A branch that is also flagged as a jump resolves as a jump.
  assign w_act = e_is_jump || (e_is_branch && e_taken);

  assign e_mispredict  = e_valid && ((w_act != e_pred_taken) ||
                                     (w_act && (e_target != e_pred_target)));
  assign e_redirect_pc = w_act ? e_target : e_pc + XLEN'(4);

  assign perf_ctrl       = r_perf_ctrl;
  assign perf_mispredict = r_perf_mispredict;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WNT;
      end
      r_perf_ctrl       <= '0;
      r_perf_mispredict <= '0;
    end else if (e_valid) begin
      if (e_is_branch || e_is_jump) r_perf_ctrl <= r_perf_ctrl + CNT_W'(1);
      if (e_mispredict) r_perf_mispredict <= r_perf_mispredict + CNT_W'(1);

      if (w_e_hit) begin
        if (e_is_jump) begin
          r_target[w_e_idx] <= e_target;
          r_jump[w_e_idx]   <= 1'b1;
        end else if (e_is_branch) begin
          if (e_taken) begin
            if (r_ctr[w_e_idx] != CTR_MAX) r_ctr[w_e_idx] <= r_ctr[w_e_idx] + CTR_ONE;
            r_target[w_e_idx] <= e_target;
          end else if (r_ctr[w_e_idx] != '0) begin
            r_ctr[w_e_idx] <= r_ctr[w_e_idx] - CTR_ONE;
          end
          r_jump[w_e_idx] <= 1'b0;
        end else begin
          // Non-control instruction aliased onto this entry: drop it.
          r_valid[w_e_idx] <= 1'b0;
        end
      end else if (w_act) begin
        r_valid[w_e_idx]  <= 1'b1;
        r_tag[w_e_idx]    <= w_e_tag;
        r_target[w_e_idx] <= e_target;
        r_jump[w_e_idx]   <= e_is_jump;
        r_ctr[w_e_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        e_valid;
  logic [31:0] e_pc;
  logic        e_is_branch;
  logic        e_is_jump;
  logic        e_taken;
  logic [31:0] e_target;
  logic        e_pred_taken;
  logic [31:0] e_pred_target;
  logic        e_mispredict;
  logic [31:0] e_redirect_pc;
  logic [31:0] perf_ctrl;
  logic [31:0] perf_mispredict;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_W(2), .CNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .e_valid(e_valid), .e_pc(e_pc), .e_is_branch(e_is_branch), .e_is_jump(e_is_jump),
    .e_taken(e_taken), .e_target(e_target), .e_pred_taken(e_pred_taken),
    .e_pred_target(e_pred_target), .e_mispredict(e_mispredict),
    .e_redirect_pc(e_redirect_pc), .perf_ctrl(perf_ctrl), .perf_mispredict(perf_mispredict)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ex(input logic v, input logic [31:0] pc, input logic br, input logic jp,
                    input logic tk, input logic [31:0] tgt, input logic pt,
                    input logic [31:0] ptgt);
    e_valid = v; e_pc = pc; e_is_branch = br; e_is_jump = jp; e_taken = tk;
    e_target = tgt; e_pred_taken = pt; e_pred_target = ptgt;
  endtask

  task automatic idle();
    ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset held while a valid taken branch is offered: entry must stay invalid.
    reset = 1'b1;
    f_pc  = 32'h0100_0000;
    ex(1'b1, 32'h0100_0010, 1'b1, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_pred_taken", {31'b0, f_pred_taken}, 32'd0);
    chk("rst_pred_target", f_pred_target, 32'h0100_0004);
    chk("rst_perf_ctrl", perf_ctrl, 32'd0);
    chk("rst_perf_mis", perf_mispredict, 32'd0);
    reset = 1'b0;
    idle();
    f_pc = 32'h0100_0010;
    #1;
    chk("rst_prio_entry_invalid", {31'b0, f_pred_taken}, 32'd0);

    // First taken branch allocates; lookup in the same cycle sees old contents.
    ex(1'b1, 32'h0100_0010, 1'b1, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 32'h0);
    #1;
    chk("br1_mispredict", {31'b0, e_mispredict}, 32'd1);
    chk("br1_redirect", e_redirect_pc, 32'h0100_0000);
    chk("br1_same_cycle", {31'b0, f_pred_taken}, 32'd0);
    tick();
    idle();
    #1;
    chk("br1_pred_taken", {31'b0, f_pred_taken}, 32'd1);
    chk("br1_pred_target", f_pred_target, 32'h0100_0000);
    chk("br1_perf_ctrl", perf_ctrl, 32'd1);
    chk("br1_perf_mis", perf_mispredict, 32'd1);

    // Three correctly predicted taken updates: counter 2 -> 3 -> 3 (saturate).
    ex(1'b1, 32'h0100_0010, 1'b1, 1'b0, 1'b1, 32'h0100_0000, 1'b1, 32'h0100_0000);
    #1;
    chk("tk_no_mispredict", {31'b0, e_mispredict}, 32'd0);
    tick(); tick(); tick();

    // Not-taken steps down: 3 -> 2 still predicts taken.
    ex(1'b1, 32'h0100_0010, 1'b1, 1'b0, 1'b0, 32'h0100_0000, 1'b1, 32'h0100_0000);
    #1;
    chk("nt1_mispredict", {31'b0, e_mispredict}, 32'd1);
    chk("nt1_redirect", e_redirect_pc, 32'h0100_0014);
    tick();
    idle();
    #1;
    chk("nt1_still_taken", {31'b0, f_pred_taken}, 32'd1);
    ex(1'b1, 32'h0100_0010, 1'b1, 1'b0, 1'b0, 32'h0100_0000, 1'b1, 32'h0100_0000);
    tick();
    idle();
    #1;
    chk("nt2_not_taken", {31'b0, f_pred_taken}, 32'd0);
    chk("nt2_target_seq", f_pred_target, 32'h0100_0014);
    ex(1'b1, 32'h0100_0010, 1'b1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 32'h0);
    #1;
    chk("nt3_no_mispredict", {31'b0, e_mispredict}, 32'd0);
    tick(); tick();
    idle();
    #1;
    chk("nt_sat_zero", {31'b0, f_pred_taken}, 32'd0);
    chk("nt_perf_ctrl", perf_ctrl, 32'd8);
    chk("nt_perf_mis", perf_mispredict, 32'd3);

    // Two taken updates bring counter 0 -> 2 so the entry predicts taken again.
    ex(1'b1, 32'h0100_0010, 1'b1, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 32'h0);
    tick(); tick();
    idle();
    #1;
    chk("retrain_taken", {31'b0, f_pred_taken}, 32'd1);

    // Alias: same index, different tag misses.
    f_pc = 32'h0100_0050;
    #1;
    chk("alias_lookup_miss", {31'b0, f_pred_taken}, 32'd0);
    ex(1'b1, 32'h0100_0010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0100_0000);
    #1;
    chk("alias_mispredict", {31'b0, e_mispredict}, 32'd1);
    chk("alias_redirect", e_redirect_pc, 32'h0100_0014);
    tick();
    idle();
    f_pc = 32'h0100_0010;
    #1;
    chk("alias_invalidated", {31'b0, f_pred_taken}, 32'd0);
    chk("alias_perf_ctrl", perf_ctrl, 32'd10);
    chk("alias_perf_mis", perf_mispredict, 32'd6);

    // jalr allocate, retarget, then a correct prediction.
    ex(1'b1, 32'h0100_0020, 1'b0, 1'b1, 1'b0, 32'h0100_0100, 1'b0, 32'h0);
    #1;
    chk("jalr1_redirect", e_redirect_pc, 32'h0100_0100);
    tick();
    idle();
    f_pc = 32'h0100_0020;
    #1;
    chk("jalr1_pred_taken", {31'b0, f_pred_taken}, 32'd1);
    chk("jalr1_pred_target", f_pred_target, 32'h0100_0100);
    ex(1'b1, 32'h0100_0020, 1'b0, 1'b1, 1'b0, 32'h0100_0200, 1'b1, 32'h0100_0100);
    #1;
    chk("jalr2_mispredict", {31'b0, e_mispredict}, 32'd1);
    chk("jalr2_redirect", e_redirect_pc, 32'h0100_0200);
    tick();
    idle();
    #1;
    chk("jalr2_pred_target", f_pred_target, 32'h0100_0200);
    ex(1'b1, 32'h0100_0020, 1'b0, 1'b1, 1'b0, 32'h0100_0200, 1'b1, 32'h0100_0200);
    #1;
    chk("jalr3_no_mispredict", {31'b0, e_mispredict}, 32'd0);
    tick();

    // Same-cycle lookup and allocate at one PC.
    f_pc = 32'h0100_0030;
    ex(1'b1, 32'h0100_0030, 1'b1, 1'b0, 1'b1, 32'h0100_0040, 1'b0, 32'h0);
    #1;
    chk("rw_same_cycle", {31'b0, f_pred_taken}, 32'd0);
    tick();
    idle();
    #1;
    chk("rw_next_cycle", {31'b0, f_pred_taken}, 32'd1);
    chk("rw_next_target", f_pred_target, 32'h0100_0040);

    // Bubble: no mispredict, counters hold.
    ex(1'b0, 32'h0100_0030, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0100_0040);
    #1;
    chk("bubble_mispredict", {31'b0, e_mispredict}, 32'd0);
    tick();
    chk("bubble_perf_ctrl", perf_ctrl, 32'd14);
    chk("bubble_perf_mis", perf_mispredict, 32'd9);
    chk("bubble_entry_held", {31'b0, f_pred_taken}, 32'd1);

    // Branch and jump both set resolves as a jump, even with e_taken low.
    ex(1'b1, 32'h0100_0060, 1'b1, 1'b1, 1'b0, 32'h0100_0300, 1'b0, 32'h0);
    #1;
    chk("bj_redirect", e_redirect_pc, 32'h0100_0300);
    tick();
    ex(1'b1, 32'h0100_0060, 1'b1, 1'b1, 1'b0, 32'h0100_0300, 1'b1, 32'h0100_0300);
    #1;
    chk("bj_no_mispredict", {31'b0, e_mispredict}, 32'd0);
    tick();
    idle();
    f_pc = 32'h0100_0060;
    #1;
    chk("bj_still_taken", {31'b0, f_pred_taken}, 32'd1);
    chk("bj_perf_ctrl", perf_ctrl, 32'd16);
    chk("bj_perf_mis", perf_mispredict, 32'd10);

    // Fall-through wraps at the top of the address space.
    f_pc = 32'hFFFF_FFFC;
    #1;
    chk("wrap_target", f_pred_target, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised branch target buffer with saturating-counter direction prediction. It replaces the fixed "predict not-taken, flush on taken" policy of the 5-stage RV32I pipeline. Fetch queries it combinationally with f_pc, and execute trains it with resolved control-flow outcomes. It also generates the mispredict/redirect signal and performance counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB entries; power of 2, >=2; IDX_W = log2(ENTRIES)
CTR_W, 2, direction counter width, >=1
CNT_W, 32, performance counter width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
f_pc  input  XLEN  fetch PC
f_pred_taken  output  1  predict taken for f_pc
f_pred_target  output  XLEN  next fetch PC: BTB target if f_pred_taken, else f_pc+4
e_valid  input  1  execute slot holds a real instruction (0 for bubbles/flushed nops)
e_pc  input  XLEN  PC of execute instruction
e_is_branch  input  1  conditional branch (B type)
e_is_jump  input  1  jal or jalr
e_taken  input  1  resolved branch outcome; ignored unless e_is_branch
e_target  input  XLEN  resolved target
e_pred_taken  input  1  prediction carried from fetch with this instruction
e_pred_target  input  XLEN  predicted target carried from fetch
e_mispredict  output  1  flush D/X and redirect fetch
e_redirect_pc  output  XLEN  correct next PC
perf_ctrl  output  CNT_W  count of resolved control-flow instructions
perf_mispredict  output  CNT_W  count of mispredicts

Behaviour:
- Entry fields: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN], jump bit, ctr[CTR_W]. Index = pc[IDX_W+1:2]. pc[1:0] is ignored.
- Reset (synchronous, priority over every update):
  - all valid=0, ctr=2^(CTR_W-1)-1, perf counters 0.
  - Outputs then give f_pred_taken=0 and f_pred_target=f_pc+4.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - f_pred_taken = hit && (jump || ctr[CTR_W-1]).
- Actual direction: act = e_is_jump || (e_is_branch && e_taken). If e_is_branch and e_is_jump are both high, the instruction is treated as a jump.
- e_mispredict = e_valid && ((act != e_pred_taken) || (act && e_target != e_pred_target)).
  - A non-control instruction predicted taken (alias) is a mispredict.
- e_redirect_pc = act ? e_target : e_pc+4. It is only meaningful when e_mispredict=1.
- Update on rising edge, only when e_valid=1 (BTB hit is evaluated at e_pc):
  - Branch, hit: ctr +1 if taken / -1 if not, saturating at 2^CTR_W-1 and 0. If taken, target<=e_target. jump<=0.
  - Jump, hit: target<=e_target, jump<=1, ctr unchanged.
  - Miss, act=1: allocate (overwrite). valid=1, tag, target=e_target, jump=e_is_jump, ctr=2^(CTR_W-1) (weakly taken).
  - Miss, act=0: no change. There is no allocation for not-taken branches.
  - Non-control instruction, hit: valid<=0 (alias invalidation).
- Same cycle, same index lookup and update: lookup returns pre-update contents. The new contents are visible the next cycle.
- Performance counters (wrap modulo 2^CNT_W):
  - perf_ctrl += 1 when e_valid && (e_is_branch || e_is_jump).
  - perf_mispredict += 1 when e_mispredict.
- e_valid=0: table and counters hold; e_mispredict=0.
- Arithmetic: +4 and comparisons are XLEN-bit, modulo 2^XLEN. f_pc = 2^XLEN-4 gives f_pred_target = 0.

Test Plan:
1. Reset with f_pc=0x01000000 -> f_pred_taken=0, f_pred_target=0x01000004, perf_ctrl=perf_mispredict=0. Reset asserted in the same cycle as a valid taken update -> entry stays invalid.
2. Branch at e_pc=0x01000010, e_taken=1, e_target=0x01000000, e_pred_taken=0 -> e_mispredict=1, e_redirect_pc=0x01000000. Next cycle, f_pc=0x01000010 -> f_pred_taken=1, f_pred_target=0x01000000. perf_ctrl=1, perf_mispredict=1.
3. Continue case 2 (CTR_W=2):
   - Two more taken updates -> ctr=3.
   - First not-taken with e_pred_taken=1 -> e_mispredict=1, redirect 0x01000014, ctr=2, still predicts taken.
   - Second not-taken -> ctr=1, f_pred_taken=0.
   - Two further not-taken -> ctr saturates at 0.
4. Alias (ENTRIES=16), with the entry from case 2 valid:
   - f_pc=0x01000050 (same index 4, different tag) -> f_pred_taken=0.
   - Non-control instruction e_pc=0x01000010 with e_pred_taken=1 -> e_mispredict=1, redirect 0x01000014. Next cycle, f_pc=0x01000010 -> f_pred_taken=0.
5. jalr at 0x01000020:
   - First resolve, target 0x01000100 -> allocated, jump=1.
   - Second resolve, e_target=0x01000200, e_pred_taken=1, e_pred_target=0x01000100 -> e_mispredict=1, redirect 0x01000200. Next lookup target = 0x01000200.
6. Same-cycle read/write: f_pc=e_pc=0x01000030 while allocating -> f_pred_taken=0 that cycle, 1 the next cycle. Bubble (e_valid=0, e_pred_taken=1) -> e_mispredict=0, counters unchanged.
